// File: rtl/cache_fill_pkg.sv
// Shared definitions for the cache-miss fill controller: FSM encoding and
// helpers that derive index, counter and offset widths from WORDS and BYTE_OFF.
package cache_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        TAG  = 2'b10
    } fill_state_t;

    // Bits needed to index one word inside a block.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // One extra bit so a counter can hold WORDS itself.
    function automatic int cnt_width(input int words);
        return idx_width(words) + 1;
    endfunction

    // Address bits below the tag/index boundary of a block.
    function automatic int off_width(input int words, input int byte_off);
        return idx_width(words) + byte_off;
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_word_onehot_dec.sv
// Binary word index to one-hot data-array word enable; all zero when disabled.
module word_onehot_dec
    import cache_fill_pkg::*;
#(
    parameter int WORDS = 8,
    parameter int IDX_W = idx_width(WORDS)
) (
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [WORDS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache-miss block fill controller: issues one read per word, steers returns
// into the data array, then writes the tag. Option: CRITICAL_WORD_FIRST_EN.
module cache_fill_ctrl
    import cache_fill_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int WORDS    = 8,
    parameter int BYTE_OFF = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              fsm_busy,
    output logic              stall,
    output logic              write_data_array,
    output logic [WORDS-1:0]  wrd_en,
    output logic [DATA_W-1:0] fill_data,
    output logic              write_tag_array,
    output logic              fill_done,
`ifdef CRITICAL_WORD_FIRST_EN
    output logic              crit_word_valid,
`endif
    output logic [1:0]        dbg_state
);

    localparam int IDX_W = idx_width(WORDS);
    localparam int CNT_W = cnt_width(WORDS);
    localparam int OFF_W = off_width(WORDS, BYTE_OFF);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    fill_state_t       state, state_nxt;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  start_q, start_d;
    logic [CNT_W-1:0]  iss_cnt, rcv_cnt;
    logic [IDX_W-1:0]  iss_idx, rcv_idx;
    logic              capture, issue, accept, last_rcv;

    assign base_d = miss_address & ~OFF_MASK;
`ifdef CRITICAL_WORD_FIRST_EN
    assign start_d = IDX_W'(miss_address >> BYTE_OFF);
`else
    assign start_d = '0;
`endif

    // Word indices wrap inside the block by truncation to IDX_W bits.
    assign iss_idx  = start_q + iss_cnt[IDX_W-1:0];
    assign rcv_idx  = start_q + rcv_cnt[IDX_W-1:0];

    assign capture  = (state == IDLE) && miss_detected;
    assign mem_req  = (state == FILL) && (iss_cnt < CNT_W'(WORDS));
    assign issue    = mem_req && mem_ready;
    assign accept   = (state == FILL) && mem_rvalid && (rcv_cnt < iss_cnt);
    assign last_rcv = accept && (rcv_cnt == CNT_W'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            base_q  <= '0;
            start_q <= '0;
            iss_cnt <= '0;
            rcv_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                base_q  <= base_d;
                start_q <= start_d;
                iss_cnt <= '0;
                rcv_cnt <= '0;
            end else begin
                if (issue)  iss_cnt <= iss_cnt + CNT_W'(1);
                if (accept) rcv_cnt <= rcv_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (miss_detected) state_nxt = FILL;
            FILL:    if (last_rcv)      state_nxt = TAG;
            TAG:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    word_onehot_dec #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_dec (
        .en     (accept),
        .idx    (rcv_idx),
        .onehot (wrd_en)
    );

    assign mem_addr         = mem_req ? (base_q | (ADDR_W'(iss_idx) << BYTE_OFF)) : '0;
    assign fsm_busy         = (state != IDLE);
    assign stall            = fsm_busy || capture;
    assign write_data_array = accept;
    assign fill_data        = accept ? mem_rdata : '0;
    assign write_tag_array  = (state == TAG);
    assign fill_done        = (state == TAG);
    assign dbg_state        = state;
`ifdef CRITICAL_WORD_FIRST_EN
    // First accepted word of the fill is the missed word: early restart.
    assign crit_word_valid  = accept && (rcv_cnt == '0);
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: cycle table, directed corner cases
// and randomized fills against an in-order memory model and expected queues.
module tb_cache_fill_ctrl;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int WORDS    = 8;
    localparam int BYTE_OFF = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              fsm_busy;
    logic              stall;
    logic              write_data_array;
    logic [WORDS-1:0]  wrd_en;
    logic [DATA_W-1:0] fill_data;
    logic              write_tag_array;
    logic              fill_done;
    logic [1:0]        dbg_state;

    logic              miss4;
    logic [15:0]       addr4;
    logic              ready4;
    logic              rvalid4;
    logic [15:0]       rdata4;
    logic              req4;
    logic [15:0]       maddr4;
    logic              busy4;
    logic              stall4;
    logic              wr4;
    logic [3:0]        wen4;
    logic [15:0]       fdata4;
    logic              tag4;
    logic              done4;
    logic [1:0]        state4;
`ifdef CRITICAL_WORD_FIRST_EN
    logic              crit_word_valid;
    logic              crit4;
`endif

    always #5 clk = ~clk;

    cache_fill_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .BYTE_OFF(BYTE_OFF)
    ) u_dut (
        .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .fsm_busy(fsm_busy), .stall(stall),
        .write_data_array(write_data_array), .wrd_en(wrd_en), .fill_data(fill_data),
        .write_tag_array(write_tag_array), .fill_done(fill_done),
`ifdef CRITICAL_WORD_FIRST_EN
        .crit_word_valid(crit_word_valid),
`endif
        .dbg_state(dbg_state)
    );

    cache_fill_ctrl #(
        .ADDR_W(16), .DATA_W(16), .WORDS(4), .BYTE_OFF(1)
    ) u_dut4 (
        .clk(clk), .rst(rst), .miss_detected(miss4), .miss_address(addr4),
        .mem_ready(ready4), .mem_rvalid(rvalid4), .mem_rdata(rdata4),
        .mem_req(req4), .mem_addr(maddr4), .fsm_busy(busy4), .stall(stall4),
        .write_data_array(wr4), .wrd_en(wen4), .fill_data(fdata4),
        .write_tag_array(tag4), .fill_done(done4),
`ifdef CRITICAL_WORD_FIRST_EN
        .crit_word_valid(crit4),
`endif
        .dbg_state(state4)
    );

    typedef struct {
        logic              miss;
        logic              rvalid;
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [WORDS-1:0]  wen;
        logic              tag;
        logic              busy;
        logic              stall;
        logic              crit;
        logic [1:0]        st;
    } vec_t;

    vec_t              vecs [13];
    logic [ADDR_W-1:0] tbl_addr [8];
    logic [WORDS-1:0]  tbl_wen [8];
    logic [15:0]       exp4 [4];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_req, n_wr, n_tag, wr_in_fill;
    bit sb_en;
    int ready_mode;
    int lat;
    bit rand_rv;

    logic [ADDR_W-1:0] exp_addr_q [$];
    logic [ADDR_W-1:0] exp_wr_q [$];
    logic [ADDR_W-1:0] pend_addr [$];
    int                pend_due [$];

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_msg(input string name, input string what);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // Expected order of one fill, computed from the block base and start word.
    task automatic start_fill(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] base, wa;
        int st;
        base = a & ~ADDR_W'((WORDS << BYTE_OFF) - 1);
`ifdef CRITICAL_WORD_FIRST_EN
        st = int'((a >> BYTE_OFF) % WORDS);
`else
        st = 0;
`endif
        for (int i = 0; i < WORDS; i++) begin
            wa = base | ADDR_W'(((st + i) % WORDS) << BYTE_OFF);
            exp_addr_q.push_back(wa);
            exp_wr_q.push_back(wa);
        end
        wr_in_fill = 0;
        miss_address = a;
        miss_detected = 1'b1;
    endtask

    task automatic scoreboard();
        logic [ADDR_W-1:0] a;
        if (mem_req && mem_ready) begin
            n_req++;
            pend_addr.push_back(mem_addr);
            pend_due.push_back(cyc + lat);
            if (exp_addr_q.size() == 0) fail_msg("extra_req", $sformatf("addr 0x%0h not expected", mem_addr));
            else check("req_addr", mem_addr, exp_addr_q.pop_front());
        end
        if (write_data_array) begin
            n_wr++;
            if (exp_wr_q.size() == 0) fail_msg("extra_write", $sformatf("wrd_en 0x%0h not expected", wrd_en));
            else begin
                a = exp_wr_q.pop_front();
                check("wrd_en", wrd_en, 32'(1) << ((a >> BYTE_OFF) % WORDS));
                check("fill_data", fill_data, mem_word(a));
            end
`ifdef CRITICAL_WORD_FIRST_EN
            check("crit_word_valid", crit_word_valid, wr_in_fill == 0);
`endif
            wr_in_fill++;
        end else begin
            check("wrd_en_quiet", wrd_en, 0);
`ifdef CRITICAL_WORD_FIRST_EN
            check("crit_quiet", crit_word_valid, 0);
`endif
        end
        if (write_tag_array) begin
            n_tag++;
            check("tag_after_all_writes", exp_wr_q.size(), 0);
        end
    endtask

    // In-order memory: a request accepted in cycle c returns no earlier than c+lat.
    task automatic drive_mem();
        if (ready_mode == 1) mem_ready = 1'b1;
        else if (ready_mode == 2) mem_ready = ($urandom_range(0, 3) != 0);
        mem_rvalid = 1'b0;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc && (!rand_rv || $urandom_range(0, 2) != 0)) begin
            mem_rvalid = 1'b1;
            mem_rdata = mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (sb_en) scoreboard();
        @(posedge clk);
        #1;
        cyc++;
        drive_mem();
    endtask

    task automatic clear_model();
        exp_addr_q.delete();
        exp_wr_q.delete();
        pend_addr.delete();
        pend_due.delete();
    endtask

    task automatic run_fill(input logic [ADDR_W-1:0] a, input int budget);
        int t0, k;
        t0 = n_tag;
        start_fill(a);
        step();
        miss_detected = 1'b0;
        k = 0;
        while (n_tag == t0 && k < budget) begin
            step();
            k++;
        end
        if (n_tag == t0) fail_msg("fill_timeout", $sformatf("no tag write for miss 0x%0h", a));
        check("fill_reqs_left", exp_addr_q.size(), 0);
        check("fill_writes_left", exp_wr_q.size(), 0);
        clear_model();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n4, w4, t4;
        logic [ADDR_W-1:0] hold;

        rst = 1'b1; miss_detected = 1'b0; miss_address = '0;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        miss4 = 1'b0; addr4 = '0; ready4 = 1'b1; rvalid4 = 1'b0; rdata4 = 16'hBEEF;
        sb_en = 1'b0; ready_mode = 1; lat = 2; rand_rv = 1'b0;
        n_req = 0; n_wr = 0; n_tag = 0; wr_in_fill = 0;

`ifdef CRITICAL_WORD_FIRST_EN
        tbl_addr = '{16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234};
        tbl_wen  = '{8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};
        exp4     = '{16'hFFFE, 16'hFFF8, 16'hFFFA, 16'hFFFC};
`else
        tbl_addr = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
        tbl_wen  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        exp4     = '{16'hFFF8, 16'hFFFA, 16'hFFFC, 16'hFFFE};
`endif
        // Cycle table for miss 0x1236, ready=1, latency 2 (cycle 0 = miss).
        for (int c = 0; c < 13; c++) begin
            vecs[c].miss   = (c == 0);
            vecs[c].rvalid = (c >= 3 && c <= 10);
            vecs[c].req    = (c >= 1 && c <= 8);
            vecs[c].addr   = '0;
            if (c >= 1 && c <= 8) vecs[c].addr = tbl_addr[c-1];
            vecs[c].wr     = (c >= 3 && c <= 10);
            vecs[c].wen    = '0;
            if (c >= 3 && c <= 10) vecs[c].wen = tbl_wen[c-3];
            vecs[c].tag    = (c == 11);
            vecs[c].busy   = (c >= 1 && c <= 11);
            vecs[c].stall  = (c <= 11);
            vecs[c].crit   = (c == 3);
            vecs[c].st     = (c == 0 || c == 12) ? 2'b00 : ((c == 11) ? 2'b10 : 2'b01);
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", fsm_busy, 0);
        check("rst_req", mem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_wr", write_data_array, 0);
        check("rst_wen", wrd_en, 0);
        check("rst_tag", write_tag_array, 0);
        check("rst_state", dbg_state, 0);
        check("rst_busy4", busy4, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven cycle-exact fill
        for (int c = 0; c < 13; c++) begin
            miss_detected = vecs[c].miss;
            miss_address  = 16'h1236;
            mem_rvalid    = vecs[c].rvalid;
            mem_rdata     = 16'hC000 + 16'(c);
            @(negedge clk);
            check($sformatf("tbl_req[%0d]", c), mem_req, vecs[c].req);
            if (vecs[c].req) check($sformatf("tbl_addr[%0d]", c), mem_addr, vecs[c].addr);
            check($sformatf("tbl_wr[%0d]", c), write_data_array, vecs[c].wr);
            check($sformatf("tbl_wen[%0d]", c), wrd_en, vecs[c].wen);
            if (vecs[c].wr) check($sformatf("tbl_data[%0d]", c), fill_data, 16'hC000 + 16'(c));
            check($sformatf("tbl_tag[%0d]", c), write_tag_array, vecs[c].tag);
            check($sformatf("tbl_done[%0d]", c), fill_done, vecs[c].tag);
            check($sformatf("tbl_busy[%0d]", c), fsm_busy, vecs[c].busy);
            check($sformatf("tbl_stall[%0d]", c), stall, vecs[c].stall);
            check($sformatf("tbl_state[%0d]", c), dbg_state, vecs[c].st);
`ifdef CRITICAL_WORD_FIRST_EN
            check($sformatf("tbl_crit[%0d]", c), crit_word_valid, vecs[c].crit);
`endif
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;

        // mem_ready low in cycles 2..4
        sb_en = 1'b1; ready_mode = 0; lat = 2; rand_rv = 1'b0;
        n_req = 0; n_wr = 0; n_tag = 0;
        mem_ready = 1'b1;
        start_fill(16'h1236);
        hold = exp_addr_q[1];
        step();
        miss_detected = 1'b0;
        k = 1;
        while (n_tag == 0 && k < 60) begin
            mem_ready = !(k >= 2 && k <= 4);
            if (k >= 2 && k <= 4) begin
                check("hold_addr", mem_addr, hold);
                check("hold_req", mem_req, 1);
            end
            step();
            k++;
        end
        if (n_tag == 0) fail_msg("ready_low_timeout", "no tag write");
        check("ready_low_reqs", n_req, 8);
        check("ready_low_writes", n_wr, 8);
        repeat (4) step();
        check("ready_low_single_tag", n_tag, 1);
        clear_model();
        ready_mode = 1;

        // Spurious mem_rvalid while idle
        for (int c = 0; c < 3; c++) begin
            mem_rvalid = 1'b1;
            mem_rdata = 16'h7777;
            @(negedge clk);
            check("idle_rvalid_wr", write_data_array, 0);
            check("idle_rvalid_wen", wrd_en, 0);
            check("idle_rvalid_busy", fsm_busy, 0);
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;

        // miss_detected held high through the fill
        n_req = 0; n_tag = 0; n_wr = 0;
        start_fill(16'h3456);
        k = 0;
        while (n_tag == 0 && k < 60) begin
            step();
            k++;
        end
        if (n_tag == 0) fail_msg("held_miss_timeout", "no tag write");
        check("held_miss_reqs", n_req, 8);
        @(negedge clk);
        check("held_idle_busy", fsm_busy, 0);
        check("held_idle_stall", stall, 1);
        check("held_idle_req", mem_req, 0);
        start_fill(16'h3456);
        @(posedge clk); #1;
        cyc++;
        drive_mem();
        miss_detected = 1'b0;
        check("refill_busy", fsm_busy, 1);
        check("refill_req", mem_req, 1);
        k = 0;
        while (n_tag == 1 && k < 60) begin
            step();
            k++;
        end
        if (n_tag == 1) fail_msg("refill_timeout", "no tag write");
        check("refill_writes", n_wr, 16);
        check("refill_left", exp_wr_q.size(), 0);
        clear_model();

        // Reset in cycle 5 of a fill
        sb_en = 1'b0;
        start_fill(16'h2222);
        clear_model();
        step();
        miss_detected = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 16'h1111;
        @(negedge clk);
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_busy", fsm_busy, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wr", write_data_array, 0);
        check("mid_rst_wen", wrd_en, 0);
        check("mid_rst_data", fill_data, 0);
        check("mid_rst_tag", write_tag_array, 0);
        check("mid_rst_done", fill_done, 0);
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_rvalid_wr", write_data_array, 0);
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
        sb_en = 1'b1; n_tag = 0;
        run_fill(16'h4000, 80);
        check("post_rst_fill_tags", n_tag, 1);

        // WORDS=4 wrap stays inside the block at 0xFFFE
        miss4 = 1'b1;
        addr4 = 16'hFFFE;
        @(posedge clk); #1;
        miss4 = 1'b0;
        n4 = 0; w4 = 0; t4 = 0;
        for (int c = 1; c < 20; c++) begin
            rvalid4 = (c >= 2);
            @(negedge clk);
            if (req4) begin
                if (n4 < 4) check($sformatf("w4_addr[%0d]", n4), maddr4, exp4[n4]);
                n4++;
            end
            if (wr4) w4++;
            if (tag4) t4++;
            @(posedge clk); #1;
        end
        rvalid4 = 1'b0;
        check("w4_reqs", n4, 4);
        check("w4_writes", w4, 4);
        check("w4_tags", t4, 1);

        // Randomized fills: random ready, latency and return gaps
        ready_mode = 2; rand_rv = 1'b1; n_tag = 0;
        for (int f = 0; f < 12; f++) begin
            lat = $urandom_range(1, 4);
            run_fill(16'($urandom_range(0, 16'hFFFF)), 300);
            repeat ($urandom_range(0, 3)) step();
        end
        check("rand_tags", n_tag, 12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Parametrised cache-miss fill controller between the cache tag-match logic and the memory port. On a miss it issues one memory read per word of the missing block, with a ready handshake and optional critical-word-first wrap-around ordering. It steers each returned word into the data array with a one-hot word enable, then writes the tag once the block is complete. It stalls the pipeline for the whole fill and replaces the fixed 8-word, fixed-latency fill controller.

## Interface
- ADDR_W, 16, address width in bits
- DATA_W, 16, memory/cache word width
- WORDS, 8, words per block; power of two, ≥2
- BYTE_OFF, 1, log2 bytes per word
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- miss_detected  in  1  tag-match miss, level; sampled only in IDLE
- miss_address  in  ADDR_W  missing address; captured with the miss
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  read data valid; returns are in request order, latency ≥1
- mem_rdata  in  DATA_W  read data
- mem_req  out  1  read request valid
- mem_addr  out  ADDR_W  read address
- fsm_busy  out  1  state ≠ IDLE
- stall  out  1  fsm_busy | (IDLE & miss_detected)
- write_data_array  out  1  data-array write strobe
- wrd_en  out  WORDS  one-hot data-array word enable
- fill_data  out  DATA_W  mem_rdata passed through, qualified by write_data_array
- write_tag_array  out  1  tag-array write strobe
- fill_done  out  1  one-cycle pulse in the TAG cycle
- crit_word_valid  out  1  present only with CRITICAL_WORD_FIRST_EN

## Operation
- States: IDLE, FILL, TAG.
- IDLE:
  - miss_detected=1 captures base = miss_address with the low log2(WORDS)+BYTE_OFF bits zeroed.
  - It also captures start = the word-index field, or 0 without the macro.
  - It clears iss_cnt and rcv_cnt, then goes to FILL.
- FILL, issue side:
  - mem_req = (iss_cnt < WORDS).
  - mem_addr = base | (((start+iss_cnt) mod WORDS) << BYTE_OFF). The wrap-around comes from truncating to log2(WORDS) bits.
  - iss_cnt increments on mem_req & mem_ready.
- FILL, return side:
  - A return is accepted when mem_rvalid & (rcv_cnt < iss_cnt).
  - On acceptance: write_data_array=1 and wrd_en = onehot((start+rcv_cnt) mod WORDS); rcv_cnt increments.
  - mem_rvalid when rcv_cnt ≥ iss_cnt is ignored, with no write.
  - The accepted return with rcv_cnt = WORDS-1 moves the state to TAG.
- TAG: write_tag_array=1, fill_done=1, fsm_busy=1 for one cycle, then IDLE.
- Counters are log2(WORDS)+1 bits wide, so WORDS itself is representable.
- Ignored inputs:
  - miss_detected outside IDLE.
  - mem_rvalid in IDLE or TAG.
  - Changes of miss_address after capture.
- The outputs below are 0 when inactive: mem_req, write_data_array, write_tag_array, fill_done, crit_word_valid, and all bits of wrd_en.

## Timing
- Reset, including reset mid-fill:
  - State returns to IDLE and the counters clear.
  - All outputs are 0 in the next cycle, except stall, which follows miss_detected.
  - Outstanding returns arriving after reset are ignored.
- Miss in cycle 0 gives stall=1 in cycle 0, FILL in cycle 1, and the first mem_req in cycle 1.
- With mem_ready held 1 and latency L: requests in cycles 1..WORDS, returns in cycles 1+L..WORDS+L, TAG in cycle WORDS+L+1, IDLE in WORDS+L+2.
- The last issue and the first return may fall in the same cycle; both counters update.
- mem_ready low holds mem_addr and iss_cnt stable.
- write_data_array, wrd_en and fill_data are combinational from mem_rvalid in the same cycle.

## Configuration
- CRITICAL_WORD_FIRST_EN defined:
  - The fill starts at the missed word and wraps modulo WORDS.
  - crit_word_valid pulses together with the write of the first (missed) word, for early restart.
- CRITICAL_WORD_FIRST_EN undefined:
  - start = 0, so the fill order is word 0..WORDS-1.
  - The crit_word_valid port is absent.

## Structure
- Package cache_fill_pkg:
  - State encodings: IDLE=2'b00, FILL=2'b01, TAG=2'b10.
  - Counter-width and offset-width constants derived from WORDS and BYTE_OFF.
- One sub-module, word_onehot_dec: a parametrised binary-to-one-hot decoder (WORDS outputs) producing wrd_en.

## Test plan
- ADDR_W=16, WORDS=8, BYTE_OFF=1, macro on, ready=1, L=2, miss 0x1236:
  - mem_addr sequence 0x1236,0x1238,0x123A,0x123C,0x123E,0x1230,0x1232,0x1234.
  - wrd_en 0x08,0x10,0x20,0x40,0x80,0x01,0x02,0x04.
  - TAG in cycle 11.
  - crit_word_valid in cycle 3 only.
- Same stimulus, macro off: addresses 0x1230..0x123E in steps of 2, wrd_en 0x01..0x80, no crit_word_valid port.
- mem_ready low in cycles 2–4:
  - mem_addr holds 0x1238 during the stall.
  - Total of 8 requests and 8 data writes, then exactly one write_tag_array.
- Spurious inputs:
  - mem_rvalid=1 in IDLE produces no write.
  - miss_detected held high through FILL starts no second fill; a new fill begins only in the cycle after TAG.
- rst=1 in cycle 5 of a fill:
  - The next cycle shows IDLE with all outputs 0.
  - Later mem_rvalid pulses are ignored.
  - A new miss at 0x4000 fills 0x4000.. normally.
- WORDS=4, miss 0xFFFE: addresses 0xFFFE,0xFFF8,0xFFFA,0xFFFC, showing the wrap stays within the block with no carry into the tag.
